apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Single-master APB bridge between the RISC-V core's data-bus port and the APB peripheral slots (GPIO and its siblings). Each one-cycle core request becomes one APB transfer: SETUP, then ACCESS. The bridge decodes the address to one of four PSEL lines, muxes the selected slave's PRDATA/PREADY back, and returns a one-cycle completion pulse. A timeout terminates transfers to non-responding slaves.

## Interface
- `NUM_SLV`, 4: number of peripheral slots; fixed at 4 in this revision.
- `BASE`, 32'h1000_0000: base address of the APB window. Slot n covers `BASE + n*0x1000` through `BASE + n*0x1000 + 0xFFF`.
- `TIMEOUT`, 255: maximum ACCESS cycles without PREADY before the bridge aborts; range 1..255.

Ports:
- `PCLK`, in, 1: the single clock.
- `PRESET`, in, 1: synchronous, active-high reset.
- `req`, in, 1: one-cycle transfer request from the core.
- `we`, in, 1: 1 = write, 0 = read. Sampled with `req`.
- `addr`, in, 32: byte address. Sampled with `req`.
- `wdata`, in, 32: write data. Sampled with `req`.
- `rdata`, out, 32: read data. Valid while `ready`=1.
- `ready`, out, 1: one-cycle completion pulse.
- `err`, out, 1: qualifies `ready`. Set on decode miss or timeout.
- `busy`, out, 1: 1 whenever state ≠ IDLE.
- `PADDR`, out, 32: latched address.
- `PWRITE`, out, 1: latched `we`.
- `PWDATA`, out, 32: latched `wdata`.
- `PENABLE`, out, 1: APB enable.
- `PSEL`, out, 4: one-hot slave select.
- `PRDATA0`..`PRDATA3`, in, 32 each: slave read data.
- `PREADY0`..`PREADY3`, in, 1 each: slave ready.

## Operation
- States:
  - IDLE: waiting for a request.
  - SETUP: `PSEL[n]`=1, `PENABLE`=0.
  - ACCESS: `PSEL[n]`=1, `PENABLE`=1.
- Request acceptance:
  - In IDLE with `req`=1, the bridge latches `addr`, `we` and `wdata` into the PADDR/PWRITE/PWDATA registers and decodes the slot.
  - Slot index n = `addr[13:12]` when `addr[31:14] == BASE[31:14]`; otherwise the request is a decode miss.
- Decode miss: no APB activity. The next cycle is IDLE with `ready`=1, `err`=1 and `rdata`=0.
- Decode hit: IDLE → SETUP → ACCESS.
- In ACCESS, PREADY and PRDATA are taken only from slot n. Other slots' PREADY are ignored.
- PREADY sampled 1 in ACCESS:
  - Next cycle: IDLE, `ready`=1, `err`=0, `PSEL`=0, `PENABLE`=0.
  - `rdata` = registered PRDATAn on reads, 0 on writes.
- Timeout:
  - The 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches `TIMEOUT`, the next cycle is IDLE with `ready`=1, `err`=1, `rdata`=0, and PSEL/PENABLE dropped.
- `req` while `busy`=1 is ignored and is not queued. The core issues a new `req` only after `ready`.
- `req` in the same cycle as `ready` is accepted, because the state is already IDLE.
- PADDR/PWRITE/PWDATA hold their values from SETUP through the end of ACCESS, and keep the last values while IDLE.
- `PSEL` is never multi-hot.
- `PENABLE`=1 only in ACCESS.

## Timing
- Reset values (state IDLE):
  - `PSEL`=0, `PENABLE`=0, `PWRITE`=0, `PADDR`=0, `PWDATA`=0
  - `rdata`=0, `ready`=0, `err`=0, `busy`=0
  - timeout counter = 0
- All outputs are registered.
- Cycle numbering for a hit with a slave that is ready with zero wait (PREADY high in the first ACCESS cycle):
  - c0: IDLE, `req`=1.
  - c1: SETUP.
  - c2: ACCESS; PREADY sampled.
  - c3: `ready`=1.
  - Total latency 3 cycles.
- Each slave wait cycle adds one cycle.
- Peripherals such as GPIO register PREADY one cycle after seeing PSEL&&PENABLE. With such a slave:
  - PREADY is seen in c3 and `ready` appears in c4 (latency 4).
  - The slave's PREADY falls in the following cycle. The bridge is already in IDLE, so the stale PREADY has no effect.
- Decode miss: `ready`/`err` in c1 (latency 1).
- Timeout: `ready`/`err` asserted `TIMEOUT`+2 cycles after the SETUP cycle.
- `PRESET` asserted in any state:
  - Next cycle: IDLE with all reset values.
  - The aborted transfer produces no `ready` pulse.
  - The slave sees PSEL drop without completion.

## Test plan
- **Write hit.** `req`, `we`=1, `addr`=32'h1000_0008, `wdata`=32'hA5 to a GPIO-style slave 0 (PREADY one cycle late).
  - c1: `PSEL`=4'b0001, `PENABLE`=0, `PADDR`=32'h1000_0008, `PWDATA`=32'hA5.
  - c2–c3: `PENABLE`=1.
  - c4: `ready`=1, `err`=0, `rdata`=0.
- **Read hit, zero-wait slave.** `addr`=32'h1000_3004, slave 3 PRDATA=32'hDEAD_BEEF, PREADY=1 in the first ACCESS cycle.
  - `PSEL`=4'b1000.
  - c3: `ready`=1, `rdata`=32'hDEAD_BEEF.
- **Decode miss.** `addr`=32'h2000_0000.
  - `PSEL` stays 0 throughout.
  - c1: `ready`=1, `err`=1.
- **Timeout.** Parameter `TIMEOUT`=4; slave 1 holds PREADY=0; PREADY2=1 the whole time.
  - After 4 ACCESS cycles: `ready`=1, `err`=1, `rdata`=0.
  - PREADY2 is ignored.
- **Back-to-back and ignored request.**
  - A `req` during ACCESS → no second transfer.
  - A `req` in the `ready` cycle → SETUP on the next cycle with the new address.
- **Reset mid-transfer.** `PRESET`=1 during ACCESS.
  - Next cycle: `PSEL`=0, `PENABLE`=0, `busy`=0.
  - No `ready` pulse afterwards.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Single-master APB bridge: turns one-cycle core requests into APB SETUP/ACCESS
// transfers on one of four slots, with decode-miss and timeout termination.
module apb_master_bridge #(
    parameter int unsigned NUM_SLV = 4,
    parameter logic [31:0] BASE    = 32'h1000_0000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               req,
    input  logic               we,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               err,
    output logic               busy,
    output logic [31:0]        PADDR,
    output logic               PWRITE,
    output logic [31:0]        PWDATA,
    output logic               PENABLE,
    output logic [NUM_SLV-1:0] PSEL,
    input  logic [31:0]        PRDATA0,
    input  logic [31:0]        PRDATA1,
    input  logic [31:0]        PRDATA2,
    input  logic [31:0]        PRDATA3,
    input  logic               PREADY0,
    input  logic               PREADY1,
    input  logic               PREADY2,
    input  logic               PREADY3
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      paddr_q, paddr_d;
    logic               pwrite_q, pwrite_d;
    logic [DW-1:0]      pwdata_q, pwdata_d;
    logic               penable_q, penable_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic               addr_hit;
    logic               sel_pready;
    logic [DW-1:0]      sel_prdata;

    assign addr_hit = (addr[31:14] == BASE[31:14]);

    // Only the addressed slot's response is visible; the latched PADDR holds the slot index.
    always_comb begin
        sel_pready = 1'b0;
        sel_prdata = '0;
        case (paddr_q[13:12])
            2'd0:    begin sel_pready = PREADY0; sel_prdata = PRDATA0; end
            2'd1:    begin sel_pready = PREADY1; sel_prdata = PRDATA1; end
            2'd2:    begin sel_pready = PREADY2; sel_prdata = PRDATA2; end
            default: begin sel_pready = PREADY3; sel_prdata = PRDATA3; end
        endcase
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        penable_d = 1'b0;
        psel_d    = psel_q;
        cnt_d     = cnt_q;
        rdata_d   = '0;
        ready_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                psel_d = '0;
                if (req) begin
                    paddr_d  = addr;
                    pwrite_d = we;
                    pwdata_d = wdata;
                    if (addr_hit) begin
                        state_d = ST_SETUP;
                        psel_d  = NUM_SLV'(1) << addr[13:12];
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                penable_d = 1'b1;
                // A PREADY arriving in the final allowed cycle still completes normally.
                if (sel_pready) begin
                    state_d   = ST_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    rdata_d   = pwrite_q ? '0 : sel_prdata;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d   = ST_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                psel_d  = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            penable_q <= penable_d;
            psel_q    <= psel_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PENABLE = penable_q;
    assign PSEL    = psel_q;
    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, multi-cycle corner sequences,
// and random transfers checked against a latency/response model.
module tb_apb_master_bridge;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata, rdata, paddr, pwdata;
    logic        ready, err, busy, pwrite, penable;
    logic [3:0]  psel;
    logic [31:0] prdata [4];
    logic [3:0]  pready;

    // Slave behaviour per slot: 0 = ready after wt ACCESS cycles, 1 = GPIO-style
    // registered PREADY, 2 = never ready, 3 = PREADY tied high.
    int          mode [4];
    int          wt [4];
    logic [3:0]  gpio_q = '0;
    int          acc_cnt = 0;

    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .NUM_SLV(4),
        .BASE   (32'h1000_0000),
        .TIMEOUT(TO)
    ) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ready  (ready),
        .err    (err),
        .busy   (busy),
        .PADDR  (paddr),
        .PWRITE (pwrite),
        .PWDATA (pwdata),
        .PENABLE(penable),
        .PSEL   (psel),
        .PRDATA0(prdata[0]),
        .PRDATA1(prdata[1]),
        .PRDATA2(prdata[2]),
        .PRDATA3(prdata[3]),
        .PREADY0(pready[0]),
        .PREADY1(pready[1]),
        .PREADY2(pready[2]),
        .PREADY3(pready[3])
    );

    always @(posedge clk) begin
        acc_cnt <= penable ? acc_cnt + 1 : 0;
        for (int i = 0; i < 4; i++)
            gpio_q[i] <= psel[i] && penable && !gpio_q[i];
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            case (mode[i])
                0:       pready[i] = psel[i] && penable && (acc_cnt >= wt[i]);
                1:       pready[i] = gpio_q[i];
                2:       pready[i] = 1'b0;
                default: pready[i] = 1'b1;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: window range check, slot by division, latency = 3 + slave waits,
    // or TIMEOUT+3 when the slave would take longer than TIMEOUT waits.
    function automatic void model(input logic w, input logic [31:0] a, output int lat,
                                  output logic e, output logic [31:0] rd, output logic [3:0] ps);
        int slot;
        int waits;
        if (a < 32'h1000_0000 || a > 32'h1000_3FFF) begin
            lat = 1; e = 1'b1; rd = '0; ps = '0;
        end else begin
            slot = int'((a - 32'h1000_0000) / 32'h1000);
            ps   = 4'(1 << slot);
            case (mode[slot])
                0:       waits = wt[slot];
                1:       waits = 1;
                2:       waits = 1_000_000;
                default: waits = 0;
            endcase
            if (waits > int'(TO)) begin
                lat = int'(TO) + 3; e = 1'b1; rd = '0;
            end else begin
                lat = 3 + waits; e = 1'b0; rd = w ? 32'h0 : prdata[slot];
            end
        end
    endfunction

    task automatic run_txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int exp_lat, input logic exp_e, input logic [31:0] exp_rd,
                           input logic [3:0] exp_ps);
        int k;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        k = 1;
        check({tag, " paddr"}, paddr, a);
        check({tag, " pwrite/pwdata"}, pwdata ^ 32'(pwrite), d ^ 32'(w));
        while (!ready && k < 60) begin
            check($sformatf("%s bus c%0d", tag, k), 32'({psel, penable, busy}),
                  32'({exp_ps, (k > 1), 1'b1}));
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, 32'(k), 32'(exp_lat));
        check({tag, " err"}, 32'(err), 32'(exp_e));
        check({tag, " rdata"}, rdata, exp_rd);
        check({tag, " bus idle"}, 32'({psel, penable, busy}), 32'h0);
        @(negedge clk);
        check({tag, " ready pulse"}, 32'(ready), 32'h0);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          sl;
        int          md;
        int          wv;
        logic [31:0] prd;
        int          lat;
        logic        e;
        logic [31:0] rd;
        logic [3:0]  ps;
    } vec_t;

    vec_t vecs [10];

    task automatic default_slaves();
        for (int j = 0; j < 4; j++) begin
            mode[j]   = 3;
            wt[j]     = 0;
            prdata[j] = 32'hBAD0_0000 | 32'(j);
        end
    endtask

    initial begin
        int          k;
        logic        saw;
        int          m_lat;
        logic        m_e;
        logic [31:0] m_rd;
        logic [3:0]  m_ps;
        logic [31:0] ra;
        logic        rw;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        default_slaves();

        vecs[0] = '{1'b1, 32'h1000_0008, 32'h0000_00A5, 0, 1, 0, 32'h0,         4, 1'b0, 32'h0,         4'b0001};
        vecs[1] = '{1'b0, 32'h1000_3004, 32'h0,         3, 0, 0, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 4'b1000};
        vecs[2] = '{1'b0, 32'h2000_0000, 32'h0,         0, 3, 0, 32'h0,         1, 1'b1, 32'h0,         4'b0000};
        vecs[3] = '{1'b0, 32'h1000_1010, 32'h0,         1, 2, 0, 32'h1111_2222, 7, 1'b1, 32'h0,         4'b0010};
        vecs[4] = '{1'b0, 32'h1000_2FFC, 32'h0,         2, 0, 4, 32'h1234_5678, 7, 1'b0, 32'h1234_5678, 4'b0100};
        vecs[5] = '{1'b0, 32'h1000_2000, 32'h0,         2, 0, 5, 32'h1234_5678, 7, 1'b1, 32'h0,         4'b0100};
        vecs[6] = '{1'b0, 32'h1000_4000, 32'h0,         0, 3, 0, 32'h0,         1, 1'b1, 32'h0,         4'b0000};
        vecs[7] = '{1'b1, 32'h0FFF_FFFC, 32'h1,         0, 3, 0, 32'h0,         1, 1'b1, 32'h0,         4'b0000};
        vecs[8] = '{1'b1, 32'h1000_3000, 32'h5555,      3, 1, 0, 32'hFFFF_FFFF, 4, 1'b0, 32'h0,         4'b1000};
        vecs[9] = '{1'b0, 32'h1000_1000, 32'h0,         1, 0, 2, 32'hCAFE_0001, 5, 1'b0, 32'hCAFE_0001, 4'b0010};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst psel/penable/busy", 32'({psel, penable, busy}), 32'h0);
        check("rst ready/err/pwrite", 32'({ready, err, pwrite}), 32'h0);
        check("rst paddr", paddr, 32'h0);
        check("rst pwdata", pwdata, 32'h0);
        check("rst rdata", rdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            default_slaves();
            mode[vecs[i].sl]   = vecs[i].md;
            wt[vecs[i].sl]     = vecs[i].wv;
            prdata[vecs[i].sl] = vecs[i].prd;
            run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d,
                    vecs[i].lat, vecs[i].e, vecs[i].rd, vecs[i].ps);
        end

        // req during ACCESS is dropped, not queued
        default_slaves();
        mode[0] = 0; wt[0] = 3; prdata[0] = 32'h0BAD_F00D;
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 32'h1000_0000;
        @(negedge clk); req = 1'b0; k = 1;
        @(negedge clk); k = 2; req = 1'b1; we = 1'b1; addr = 32'h1000_2000;
        @(negedge clk); k = 3; req = 1'b0;
        while (!ready && k < 60) begin @(negedge clk); k++; end
        check("ignored-req latency", 32'(k), 32'd6);
        check("ignored-req rdata", rdata, 32'h0BAD_F00D);
        check("ignored-req paddr held", paddr, 32'h1000_0000);
        saw = 1'b0;
        repeat (4) begin @(negedge clk); saw = saw | busy | (|psel); end
        check("ignored-req no 2nd xfer", 32'(saw), 32'h0);

        // req in the ready cycle starts the next transfer immediately
        default_slaves();
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 32'h1000_0004;
        @(negedge clk); req = 1'b0; k = 1;
        while (!ready && k < 60) begin @(negedge clk); k++; end
        check("b2b first latency", 32'(k), 32'd3);
        req = 1'b1; we = 1'b1; addr = 32'h1000_1008; wdata = 32'h77;
        @(negedge clk); req = 1'b0; k = 1;
        check("b2b setup bus", 32'({psel, penable, busy}), 32'({4'b0010, 1'b0, 1'b1}));
        check("b2b setup paddr", paddr, 32'h1000_1008);
        check("b2b setup pwdata", pwdata, 32'h77);
        while (!ready && k < 60) begin @(negedge clk); k++; end
        check("b2b second latency", 32'(k), 32'd3);
        check("b2b second err", 32'(err), 32'h0);

        // Reset during ACCESS aborts silently
        default_slaves();
        mode[1] = 2;
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 32'h1000_1000;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        check("rst-mid in access", 32'({psel, penable, busy}), 32'({4'b0010, 1'b1, 1'b1}));
        rst = 1'b1;
        @(negedge clk);
        check("rst-mid bus", 32'({psel, penable, busy, ready}), 32'h0);
        check("rst-mid paddr", paddr, 32'h0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin @(negedge clk); saw = saw | ready | busy; end
        check("rst-mid no ready", 32'(saw), 32'h0);

        // Random transfers against the reference model
        for (int t = 0; t < 80; t++) begin
            for (int j = 0; j < 4; j++) begin
                mode[j]   = int'($urandom_range(0, 3));
                wt[j]     = int'($urandom_range(0, 6));
                prdata[j] = $urandom;
            end
            rw = 1'(($urandom & 1));
            if ($urandom_range(0, 4) == 0) begin
                ra = $urandom;
                if (ra[31:14] == 18'(32'h1000_0000 >> 14)) ra = ra ^ 32'h8000_0000;
            end else begin
                ra = 32'h1000_0000 + 32'($urandom_range(0, 3)) * 32'h1000 + ($urandom & 32'hFFC);
            end
            model(rw, ra, m_lat, m_e, m_rd, m_ps);
            run_txn($sformatf("rnd%0d", t), rw, ra, $urandom, m_lat, m_e, m_rd, m_ps);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
